turn_signal_sequencer: RTL
==========================

// Module: turn_signal_sequencer
// PURPOSE
//  Controls the six tail lamps (3 left, 3 right) from the left/right/hazard switch requests.
//  Left and right requests are arbitrated with hazard preemption.
//  Lamps step at a divided blink rate from an internal tick counter.
//  Sits between the debounced switch inputs and the lamp pins of the lab board top level.
// PARAMETERS
//  TICK_DIV  4  clk cycles per lamp step; legal >= 1 (4 in sim, ~25_000_000 on board)
// PORTS
//  clk      in   1  system clock; all state changes on its rising edge
//  reset    in   1  asynchronous, active-high; clears the tick counter and the FSM
//  left     in   1  left-turn request, level, synchronous to clk
//  right    in   1  right-turn request, level, synchronous to clk
//  hazard   in   1  hazard request, level, synchronous to clk
//  la,lb,lc out  1  left lamps, inner to outer
//  ra,rb,rc out  1  right lamps, inner to outer
//  busy     out  1  high whenever the FSM is not in IDLE
//  tick     out  1  single-cycle pulse when the FSM may step
// BEHAVIOUR
//  Tick counter
//   - cnt, width $clog2(TICK_DIV) (minimum 1), resets to 0.
//   - Counts 0..TICK_DIV-1 and wraps to 0.
//   - tick = (cnt == TICK_DIV-1), combinational.
//   - TICK_DIV=1 gives tick=1 every cycle.
//   - Counter free-runs; it is not reset by requests.
//  FSM
//   - Eight states: IDLE, L1, L2, L3, R1, R2, R3, LR3. Reset state is IDLE.
//   - State register changes only on an edge where tick=1; otherwise it holds.
//  Transitions (evaluated on each tick edge)
//   IDLE: hzd = hazard | (left & right)
//         hzd                                  -> LR3
//         else left                            -> L1
//         else right                           -> R1
//         else                                 -> IDLE
//   L1->L2->L3->IDLE; R1->R2->R3->IDLE
//         - Once started, a sequence runs to completion.
//         - The opposite-direction request is ignored until IDLE.
//   Any L*/R* state with hazard=1              -> LR3 (hazard preempts mid-sequence)
//   LR3                                        -> IDLE (hazard still high re-enters LR3 on the next tick: blink)
//  Requests
//   - Sampled only at tick edges. A request that rises and falls between ticks is lost (by design).
//  Outputs (Moore, decoded from the state register; change only at tick edges)
//   IDLE: all 0
//   L1: la;  L2: la,lb;  L3: la,lb,lc
//   R1: ra;  R2: ra,rb;  R3: ra,rb,rc
//   LR3: all six = 1
//   busy = (state != IDLE)
//  Reset
//   - Asserting reset at any time, including mid-sequence, forces within the same cycle:
//     all lamps 0, busy=0, cnt=0, state IDLE.
//   - After deassertion the first tick occurs TICK_DIV cycles later.
// TESTING (TICK_DIV=4, 10 ns clk)
//  1 reset high 50 ns, inputs 0 -> lamps 000/000, busy=0, tick every 4th cycle, cnt wraps 3->0.
//  2 left=1 held after reset -> successive ticks: la; la,lb; la,lb,lc; all off; then repeats (period 4 ticks = 16 cycles).
//  3 right=1 for a single tick -> R1,R2,R3,IDLE completes (12 cycles busy) with right low after the 1st tick.
//  4 left=right=1 in IDLE -> all six lamps on 1 tick, off 1 tick, alternating while held.
//  5 right held, hazard raised while in R2 -> next tick all six on (LR3), not R3.
//  6 left held in L2, reset pulsed 1 cycle -> lamps 0 immediately; L1 restarts 4 cycles after reset falls.
//  Extra: TICK_DIV=1 -> one step per clk. A left pulse between ticks is ignored; busy stays 0.

Source files
------------

// File: rtl/turn_signal_sequencer.sv
// Tail-lamp sequencer: arbitrates left/right/hazard requests and steps six lamps
// at a divided blink rate. Lamp and busy outputs are registered from the next state.
module turn_signal_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_L1   = 3'd1,
        S_L2   = 3'd2,
        S_L3   = 3'd3,
        S_R1   = 3'd4,
        S_R2   = 3'd5,
        S_R3   = 3'd6,
        S_LR3  = 3'd7
    } state_t;

    // Lamp pattern {la,lb,lc,ra,rb,rc} for a state; lamps fill from the inner one outward.
    function automatic logic [5:0] lamp_decode(input state_t s);
        logic [5:0] v;
        case (s)
            S_IDLE:  v = 6'b000_000;
            S_L1:    v = 6'b100_000;
            S_L2:    v = 6'b110_000;
            S_L3:    v = 6'b111_000;
            S_R1:    v = 6'b000_100;
            S_R2:    v = 6'b000_110;
            S_R3:    v = 6'b000_111;
            S_LR3:   v = 6'b111_111;
            default: v = 6'b000_000;
        endcase
        return v;
    endfunction

    logic [CW-1:0] r_cnt;
    logic          w_tick;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [5:0]    r_lamps;
    logic          r_busy;

    assign w_tick = (r_cnt == CNT_MAX);

    // Free-running step divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // State register; only advances on a step edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (w_tick) begin
            r_state <= w_state_nxt;
        end else begin
            r_state <= r_state;
        end
    end

    // Next-state logic; hazard preempts any running sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (hazard || (left && right)) begin
                    w_state_nxt = S_LR3;
                end else if (left) begin
                    w_state_nxt = S_L1;
                end else if (right) begin
                    w_state_nxt = S_R1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_L1:    w_state_nxt = hazard ? S_LR3 : S_L2;
            S_L2:    w_state_nxt = hazard ? S_LR3 : S_L3;
            S_L3:    w_state_nxt = hazard ? S_LR3 : S_IDLE;
            S_R1:    w_state_nxt = hazard ? S_LR3 : S_R2;
            S_R2:    w_state_nxt = hazard ? S_LR3 : S_R3;
            S_R3:    w_state_nxt = hazard ? S_LR3 : S_IDLE;
            S_LR3:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output registers load the decode of the state being entered, so they track r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lamps <= 6'b000_000;
            r_busy  <= 1'b0;
        end else if (w_tick) begin
            r_lamps <= lamp_decode(w_state_nxt);
            r_busy  <= (w_state_nxt != S_IDLE);
        end else begin
            r_lamps <= r_lamps;
            r_busy  <= r_busy;
        end
    end

    assign {la, lb, lc, ra, rb, rc} = r_lamps;
    assign busy = r_busy;
    assign tick = w_tick;

endmodule
